// File: rtl/stopwatch_if.sv
// Stopwatch control/display bundle: divided tick and buttons in, BCD display and status out.
interface stopwatch_if;
    logic        tick_in;
    logic        btn_start;
    logic        btn_lap;
    logic [19:0] disp_bcd;
    logic        running;
    logic        lap_hold;
    logic        wrap;

    modport master (
        output tick_in, btn_start, btn_lap,
        input  disp_bcd, running, lap_hold, wrap
    );

    modport slave (
        input  tick_in, btn_start, btn_lap,
        output disp_bcd, running, lap_hold, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch counter: edge-detects the divided tick and buttons, counts min:sec.cs in BCD,
// and runs the IDLE/RUN/LAP/STOP control FSM with a lap display latch.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned MIN_MAX  = 9
) (
    input  logic       clk,
    input  logic       rst,
    stopwatch_if.slave sw
);

    localparam int unsigned PRE_W = 4;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [3:0]       MIN_LAST = 4'(MIN_MAX);

    typedef struct packed {
        logic [3:0] min;
        logic [3:0] sec_t;
        logic [3:0] sec_u;
        logic [3:0] cs_t;
        logic [3:0] cs_u;
    } bcd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAP  = 2'd2,
        S_STOP = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             tick_q, tick_d;
    logic             start_q, start_d;
    logic             lap_q, lap_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    bcd_t             cnt_q, cnt_d;
    bcd_t             lat_q, lat_d;
    bcd_t             disp_q, disp_d;
    logic             wrap_q, wrap_d;
    logic             running_q, running_d;
    logic             lap_hold_q, lap_hold_d;

    logic tick_rise;
    logic start_rise;
    logic lap_rise;
    logic count_en;
    bcd_t cnt_inc;
    logic cnt_roll;

    assign tick_rise  = sw.tick_in   & ~tick_q;
    assign start_rise = sw.btn_start & ~start_q;
    assign lap_rise   = sw.btn_lap   & ~lap_q;
    assign count_en   = tick_rise & ((state_q == S_RUN) | (state_q == S_LAP));

    // Live count plus one centisecond, rippling BCD carries up to the minute digit
    always_comb begin
        cnt_inc  = cnt_q;
        cnt_roll = 1'b0;
        if (cnt_q.cs_u != 4'd9) begin
            cnt_inc.cs_u = cnt_q.cs_u + 4'd1;
        end else begin
            cnt_inc.cs_u = 4'd0;
            if (cnt_q.cs_t != 4'd9) begin
                cnt_inc.cs_t = cnt_q.cs_t + 4'd1;
            end else begin
                cnt_inc.cs_t = 4'd0;
                if (cnt_q.sec_u != 4'd9) begin
                    cnt_inc.sec_u = cnt_q.sec_u + 4'd1;
                end else begin
                    cnt_inc.sec_u = 4'd0;
                    if (cnt_q.sec_t != 4'd5) begin
                        cnt_inc.sec_t = cnt_q.sec_t + 4'd1;
                    end else begin
                        cnt_inc.sec_t = 4'd0;
                        if (cnt_q.min != MIN_LAST) begin
                            cnt_inc.min = cnt_q.min + 4'd1;
                        end else begin
                            cnt_inc.min = 4'd0;
                            cnt_roll    = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Next-state, prescaler, count, latch and output computation
    always_comb begin
        state_d = state_q;
        tick_d  = sw.tick_in;
        start_d = sw.btn_start;
        lap_d   = sw.btn_lap;
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        wrap_d  = 1'b0;

        if (count_en) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                cnt_d  = cnt_inc;
                wrap_d = cnt_roll;
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_RUN;
            end
            S_RUN: begin
                if (start_rise) begin
                    state_d = S_STOP;
                end else if (lap_rise) begin
                    state_d = S_LAP;
                    lat_d   = cnt_q;
                end
            end
            S_LAP: begin
                if (start_rise)    state_d = S_STOP;
                else if (lap_rise) state_d = S_RUN;
            end
            S_STOP: begin
                if (start_rise) begin
                    state_d = S_RUN;
                end else if (lap_rise) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pre_d   = '0;
                    wrap_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        disp_d     = (state_q == S_LAP) ? lat_q : cnt_q;
        running_d  = (state_d == S_RUN) | (state_d == S_LAP);
        lap_hold_d = (state_d == S_LAP);
    end

    // Edge-detect registers reset high so a level held through reset is not an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_q     <= 1'b1;
            start_q    <= 1'b1;
            lap_q      <= 1'b1;
            pre_q      <= '0;
            cnt_q      <= '0;
            lat_q      <= '0;
            disp_q     <= '0;
            wrap_q     <= 1'b0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            start_q    <= start_d;
            lap_q      <= lap_d;
            pre_q      <= pre_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            disp_q     <= disp_d;
            wrap_q     <= wrap_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign sw.disp_bcd = disp_q;
    assign sw.running  = running_q;
    assign sw.lap_hold = lap_hold_q;
    assign sw.wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: two instances (TICK_DIV=1/MIN_MAX=1 and TICK_DIV=4/MIN_MAX=9)
// share one stimulus stream; a centisecond-integer reference model predicts every cycle.
module tb_stopwatch_ctrl;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_LAP  = 2;
    localparam int M_STOP = 3;

    typedef struct packed {
        int          st;
        int          cnt;
        int          pre;
        int          lapv;
        bit          pt;
        bit          ps;
        bit          pl;
        logic [19:0] disp;
        bit          run;
        bit          lh;
        bit          wrap;
    } mdl_t;

    typedef struct packed {
        logic [19:0] disp;
        logic        run;
        logic        lh;
        logic        wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stopwatch_if if_a ();
    stopwatch_if if_b ();

    stopwatch_ctrl #(.TICK_DIV(1), .MIN_MAX(1)) dut_a (.clk(clk), .rst(rst), .sw(if_a));
    stopwatch_ctrl #(.TICK_DIV(4), .MIN_MAX(9)) dut_b (.clk(clk), .rst(rst), .sw(if_b));

    exp_t q_a[$];
    exp_t q_b[$];
    mdl_t ma;
    mdl_t mb;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cur_t = 1'b0;
    bit   cur_s = 1'b0;
    bit   cur_l = 1'b0;

    function automatic logic [19:0] bcd(input int c);
        int m;
        int s;
        int cs;
        m  = c / 6000;
        s  = (c / 100) % 60;
        cs = c % 100;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(cs / 10), 4'(cs % 10)};
    endfunction

    // One system-clock edge of the stopwatch as described by its rules
    function automatic mdl_t step(input mdl_t m, input bit r, input bit t, input bit s,
                                  input bit l, input int div, input int mm);
        mdl_t n;
        bit   tr;
        bit   sr;
        bit   lr;
        n = m;
        if (r) begin
            n.st = M_IDLE; n.cnt = 0; n.pre = 0; n.lapv = 0;
            n.pt = 1'b1; n.ps = 1'b1; n.pl = 1'b1;
            n.disp = '0; n.run = 1'b0; n.lh = 1'b0; n.wrap = 1'b0;
            return n;
        end
        tr = t && !m.pt;
        sr = s && !m.ps;
        lr = l && !m.pl;
        n.pt = t; n.ps = s; n.pl = l;
        n.disp = (m.st == M_LAP) ? bcd(m.lapv) : bcd(m.cnt);
        n.wrap = 1'b0;
        if (tr && (m.st == M_RUN || m.st == M_LAP)) begin
            n.pre = m.pre + 1;
            if (n.pre == div) begin
                n.pre = 0;
                n.cnt = m.cnt + 1;
                if (n.cnt == (mm + 1) * 6000) begin
                    n.cnt  = 0;
                    n.wrap = 1'b1;
                end
            end
        end
        case (m.st)
            M_IDLE: if (sr) n.st = M_RUN;
            M_RUN: begin
                if (sr) n.st = M_STOP;
                else if (lr) begin n.st = M_LAP; n.lapv = m.cnt; end
            end
            M_LAP: begin
                if (sr) n.st = M_STOP;
                else if (lr) n.st = M_RUN;
            end
            default: begin
                if (sr) n.st = M_RUN;
                else if (lr) begin n.st = M_IDLE; n.cnt = 0; n.pre = 0; end
            end
        endcase
        n.run = (n.st == M_RUN) || (n.st == M_LAP);
        n.lh  = (n.st == M_LAP);
        return n;
    endfunction

    function automatic exp_t to_exp(input mdl_t m);
        exp_t e;
        e.disp = m.disp;
        e.run  = m.run;
        e.lh   = m.lh;
        e.wrap = m.wrap;
        return e;
    endfunction

    // Drive one cycle of inputs and queue what both instances must show after the edge
    task automatic cycle(input bit r, input bit t, input bit s, input bit l);
        @(negedge clk);
        rst = r;
        if_a.tick_in = t; if_a.btn_start = s; if_a.btn_lap = l;
        if_b.tick_in = t; if_b.btn_start = s; if_b.btn_lap = l;
        ma = step(ma, r, t, s, l, 1, 1);
        mb = step(mb, r, t, s, l, 4, 9);
        q_a.push_back(to_exp(ma));
        q_b.push_back(to_exp(mb));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, cur_t, cur_s, cur_l);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b1, cur_s, cur_l);
            cycle(1'b0, 1'b0, cur_s, cur_l);
        end
        cur_t = 1'b0;
    endtask

    task automatic press_start();
        cycle(1'b0, cur_t, 1'b1, cur_l);
        cycle(1'b0, cur_t, 1'b0, cur_l);
        cur_s = 1'b0;
    endtask

    task automatic press_lap();
        cycle(1'b0, cur_t, cur_s, 1'b1);
        cycle(1'b0, cur_t, cur_s, 1'b0);
        cur_l = 1'b0;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cur_t = 1'b0; cur_s = 1'b0; cur_l = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    // Monitor: after every edge, pop the prediction for each instance and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a.disp_bcd", if_a.disp_bcd, e.disp);
                chk("a.running",  20'(if_a.running),  20'(e.run));
                chk("a.lap_hold", 20'(if_a.lap_hold), 20'(e.lh));
                chk("a.wrap",     20'(if_a.wrap),     20'(e.wrap));
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b.disp_bcd", if_b.disp_bcd, e.disp);
                chk("b.running",  20'(if_b.running),  20'(e.run));
                chk("b.lap_hold", 20'(if_b.lap_hold), 20'(e.lh));
                chk("b.wrap",     20'(if_b.wrap),     20'(e.wrap));
            end
        end
    end

    initial begin
        ma = '0;
        mb = '0;
        if_a.tick_in = 1'b1; if_a.btn_start = 1'b1; if_a.btn_lap = 1'b1;
        if_b.tick_in = 1'b1; if_b.btn_start = 1'b1; if_b.btn_lap = 1'b1;

        // Reset with every level high, then hold the levels: no edges may be seen
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        cur_t = 1'b1; cur_s = 1'b1; cur_l = 1'b1;
        idle_cycles(6);
        cur_t = 1'b0; cur_s = 1'b0; cur_l = 1'b0;
        idle_cycles(2);

        // Plain count: start then 100 ticks
        press_start();
        ticks(100);
        idle_cycles(3);

        // Lap freeze and release
        do_reset();
        press_start();
        ticks(42);
        press_lap();
        ticks(30);
        idle_cycles(2);
        press_lap();
        idle_cycles(3);

        // Stop holds the count, lap in STOP clears
        do_reset();
        press_start();
        ticks(315);
        press_start();
        ticks(50);
        press_lap();
        idle_cycles(3);

        // Long run through the wrap of instance a (1:59.99 -> 0:00.00)
        do_reset();
        press_start();
        ticks(12001);
        idle_cycles(3);

        // Simultaneous tick+start in RUN, then in STOP, then tick+lap in STOP
        do_reset();
        press_start();
        ticks(3);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        ticks(5);
        press_start();
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // Randomized levels with occasional mid-run reset
        for (int i = 0; i < 6000; i++) begin
            bit r;
            cur_t = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) cur_s = ~cur_s;
            if ($urandom_range(0, 29) == 0) cur_l = ~cur_l;
            r = ($urandom_range(0, 999) == 0);
            cycle(r, cur_t, cur_s, cur_l);
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain left=%0d/%0d expected=0/0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
